rr_grant_scheduler: RTL
=======================

Name: rr_grant_scheduler

Overview:
- Round-robin scheduler that shares one decoded select line among 32 requesters.
- Registers a 5-bit grant index and drives it through a 5-to-32 one-hot decode to select exactly one consumer.
- Holds the grant until the owner signals done or drops its request, then rotates priority.
- Sits in front of the 5-to-32 decode path as its sequencing and arbitration controller.

Parameters:
- N_REQ, 32, number of requesters; fixed at 2**IDX_W.
- IDX_W, 5, grant index width.
- MAX_HOLD, 16, maximum grant length in cycles; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  N_REQ  request vector; bit i is requester i.
- done  in  1  current owner releases the grant this cycle.
- grant_valid  out  1  a grant is active.
- grant_idx  out  IDX_W  index of the current owner; 0 when grant_valid=0.
- grant_onehot  out  N_REQ  decoded grant_idx, gated by grant_valid; all zero when idle.
- busy  out  1  FSM is not IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0), applies mid-grant too: state=IDLE, ptr=0, grant_valid=0, grant_idx=0, grant_onehot=0, busy=0. Any grant in progress is dropped with no completion.
- FSM states: IDLE, GRANT, GAP.
- IDLE → GRANT:
  - Taken when |req=1.
  - Winner is the first set bit searching upward from ptr, wrapping 31→0.
  - grant_idx and grant_valid are registered, so they appear the cycle after req is sampled (latency 1).
- GRANT → GAP when either of these holds:
  - done=1;
  - req[grant_idx]=0 (abort).
  - On that edge: ptr = grant_idx+1 modulo 32 (31 wraps to 0), and grant_valid=0.
- GAP → IDLE, or directly to the next GRANT:
  - GAP is always exactly 1 cycle with grant_valid=0; this guarantees no back-to-back overlap of select lines.
  - At the end of GAP, the arbitration is the same as in IDLE.
- Other cases in GRANT:
  - Stay in GRANT otherwise.
  - Changes on other req bits are ignored until release.
- done while in IDLE or GAP: ignored.
- done and dropped req in the same cycle: treated as a single release.
- grant_onehot: combinational decode of registered grant_idx AND grant_valid. At most one bit set, never glitches relative to grant_idx.
- busy=1 in GRANT and GAP.
- Arbitration width rule: index arithmetic is modulo 2**IDX_W; no out-of-range index possible.

Optional Feature:
- Macro: RR_GRANT_TIMEOUT_EN.
- Defined:
  - A hold counter (width clog2(MAX_HOLD)+1) clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches MAX_HOLD-1 with no release, the grant is forcibly released exactly like done: ptr advances and GAP is entered.
  - A 1-cycle pulse output timeout is asserted on that edge; timeout resets to 0.
- Undefined:
  - No counter and no timeout port.
  - A grant is held indefinitely until done or the request drops.

Decomposition:
- Shared package rr_sched_pkg holds:
  - IDX_W and N_REQ constants;
  - state enum {IDLE, GRANT, GAP};
  - MAX_HOLD default.
- Sub-module grant_idx_decoder: pure 5-to-32 one-hot decode with an enable input, built as tree-style 2-to-4 stages. Instantiated once to produce grant_onehot.
- Priority search (rotate-by-ptr, find-first-set) stays inline.

Test Plan:
- Reset then req=0x0000_0001 → next cycle grant_valid=1, grant_idx=0, grant_onehot=0x0000_0001, busy=1.
- req=0x8000_0001, ptr=0, done pulsed on each grant → grants 0, then 31, then 0, each separated by one GAP cycle with grant_valid=0.
- ptr=31 (after granting 30), req=0x4000_0003 → next grant idx 0, then idx 1 (wrap-around verified); idx 30 is served only after idx 1.
- Owner 5 granted, req[5] deasserted without done → grant_valid=0 next cycle, ptr=6. done while idle produces no state change.
- rst_n driven low asynchronously mid-GRANT (idx 12) → all outputs 0 immediately without a clock edge; after release, req=0x1000 → grant_idx=12 from ptr=0.
- With RR_GRANT_TIMEOUT_EN, MAX_HOLD=16, req[3] held, no done → timeout pulses on cycle 16 of grant, grant_valid drops, next grant goes to the next requester at or above index 4.

Source files
------------

// File: rtl/rr_sched_pkg.sv
// rr_sched_pkg: constants and types shared by the round-robin grant scheduler.
//   IDX_W            grant index width
//   N_REQ            number of requesters (always 2**IDX_W)
//   MAX_HOLD_DEFAULT default grant length limit for the optional timeout
//   sched_state_e    scheduler FSM states
//   dec2to4          2-to-4 one-hot decode used by the grant decoder tree
package rr_sched_pkg;

  localparam int IDX_W            = 5;
  localparam int N_REQ            = 1 << IDX_W;
  localparam int MAX_HOLD_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } sched_state_e;

  function automatic logic [3:0] dec2to4(input logic [1:0] sel);
    dec2to4 = 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/grant_idx_decoder.sv
// grant_idx_decoder: 5-to-32 one-hot decoder with enable.
// The two low index pairs each go through a 2-to-4 stage, and the top bit goes
// through an enabled 1-to-2 stage. Each output is the AND of one line from each
// stage, so exactly one output is high when en=1 and none are high when en=0.
// Ports:
//   idx     in   IDX_W  index to decode
//   en      in   1      decode enable; all outputs are zero when low
//   onehot  out  N_REQ  decoded select lines
module grant_idx_decoder
  import rr_sched_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] onehot
);

  logic [3:0] lo_dec;
  logic [3:0] mid_dec;
  logic [1:0] hi_dec;

  assign lo_dec  = dec2to4(idx[1:0]);
  assign mid_dec = dec2to4(idx[3:2]);
  assign hi_dec  = {idx[4], ~idx[4]} & {2{en}};

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_line
      localparam int HI  = gi / 16;
      localparam int MID = (gi / 4) % 4;
      localparam int LO  = gi % 4;
      assign onehot[gi] = hi_dec[HI] & mid_dec[MID] & lo_dec[LO];
    end
  endgenerate

endmodule

// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler: round-robin arbiter that hands one decoded select line
// to one of 32 requesters at a time.
// A grant is held until the owner raises done or drops its request; then one
// idle GAP cycle follows so select lines never overlap, and priority rotates
// to the index just above the released owner.
// Optional build macro: RR_GRANT_TIMEOUT_EN adds a hold counter that forces a
// release after MAX_HOLD grant cycles and pulses the timeout output.
// Ports:
//   clk           in   1      clock, rising edge
//   rst_n         in   1      asynchronous active-low reset
//   req           in   N_REQ  request vector, bit i = requester i
//   done          in   1      current owner releases the grant
//   grant_valid   out  1      a grant is active
//   grant_idx     out  IDX_W  current owner, 0 when no grant
//   grant_onehot  out  N_REQ  decoded grant, all zero when idle
//   busy          out  1      scheduler is in GRANT or GAP
//   timeout       out  1      (macro only) one-cycle pulse on forced release
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N_REQ-1:0] grant_onehot,
  output logic             busy
`ifdef RR_GRANT_TIMEOUT_EN
  ,
  output logic             timeout
`endif
);

  sched_state_e     state_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] grant_idx_reg;
  logic             grant_valid_reg;

  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] win_off;
  logic [IDX_W-1:0] win_idx_next;
  logic             any_req;
  logic             user_release;
  logic             forced_release;

  // Rotate the request vector so bit 0 is the requester at ptr; the first set
  // bit of the rotated vector is then the round-robin winner's offset.
  always_comb begin
    req_rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rot[i] = req[IDX_W'(ptr_reg + IDX_W'(i))];
    end
  end

  // Scan downward so the lowest set bit is the last one written.
  always_comb begin
    win_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_off = IDX_W'(i);
      end
    end
  end

  // Index arithmetic wraps naturally at IDX_W bits.
  assign win_idx_next = ptr_reg + win_off;
  assign any_req      = |req;

  // done and a dropped request together count as one release.
  assign user_release = done | ~req[grant_idx_reg];

`ifdef RR_GRANT_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;

  logic [HOLD_W-1:0] hold_cnt_reg;
  logic              timeout_reg;

  assign forced_release = (hold_cnt_reg == HOLD_W'(MAX_HOLD - 1));
  assign timeout        = timeout_reg;
`else
  assign forced_release = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      grant_idx_reg   <= '0;
      grant_valid_reg <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
      hold_cnt_reg    <= '0;
      timeout_reg     <= 1'b0;
`endif
    end else begin
`ifdef RR_GRANT_TIMEOUT_EN
      timeout_reg <= 1'b0;
`endif
      case (state_reg)
        // GAP arbitrates exactly like IDLE, so it always lasts one cycle.
        IDLE, GAP: begin
          if (any_req) begin
            state_reg       <= GRANT;
            grant_idx_reg   <= win_idx_next;
            grant_valid_reg <= 1'b1;
`ifdef RR_GRANT_TIMEOUT_EN
            hold_cnt_reg    <= '0;
`endif
          end else begin
            state_reg <= IDLE;
          end
        end

        // Other request bits are ignored while a grant is held.
        GRANT: begin
          if (user_release || forced_release) begin
            state_reg       <= GAP;
            ptr_reg         <= grant_idx_reg + IDX_W'(1);
            grant_idx_reg   <= '0;
            grant_valid_reg <= 1'b0;
`ifdef RR_GRANT_TIMEOUT_EN
            // A real release on the same edge is not reported as a timeout.
            timeout_reg     <= ~user_release;
`endif
          end
`ifdef RR_GRANT_TIMEOUT_EN
          else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
`endif
        end

        default: begin
          state_reg       <= IDLE;
          grant_idx_reg   <= '0;
          grant_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid = grant_valid_reg;
  assign grant_idx   = grant_idx_reg;
  assign busy        = (state_reg != IDLE);

  grant_idx_decoder u_decoder (
    .idx    (grant_idx_reg),
    .en     (grant_valid_reg),
    .onehot (grant_onehot)
  );

endmodule
